// File: rtl/spi_master_tx.sv
// -----------------------------------------------------------------------------
// spi_master_tx
//
// SPI master transmit shifter. Pulls 32-bit words from a TX FIFO over a
// valid/ready handshake and shifts them MSB-first onto sdo0..sdo3, one step per
// tx_edge strobe (the clock generator's falling-edge pulse). Standard mode
// shifts 1 bit per step on sdo0; quad mode shifts a nibble per step on
// {sdo3,sdo2,sdo1,sdo0}. clk_en_o gates the clock generator: it is high only
// while a word is loaded and bits remain to be sent.
//
// Ports
//   clk            in   system clock, all logic on its rising edge
//   rst            in   synchronous reset, active-high
//   en             in   start request, sampled in IDLE only
//   tx_edge        in   one-cycle shift strobe from the clock generator
//   en_quad_in     in   1 = quad mode, 0 = standard; latched at start
//   counter_in     in   transfer length in bits
//   counter_in_upd in   load counter_in into the length register (IDLE only)
//   data           in   TX word from the FIFO
//   data_valid     in   FIFO word available
//   data_ready     out  word consumed this cycle (data_valid & data_ready = pop)
//   clk_en_o       out  enable to the clock generator
//   tx_done        out  one-cycle pulse when the transfer completes
//   sdo0..sdo3     out  serial data lines
// -----------------------------------------------------------------------------
module spi_master_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        tx_edge,
  input  logic        en_quad_in,
  input  logic [15:0] counter_in,
  input  logic        counter_in_upd,
  input  logic [31:0] data,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        clk_en_o,
  output logic        tx_done,
  output logic        sdo0,
  output logic        sdo1,
  output logic        sdo2,
  output logic        sdo3
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRANSMIT,
    S_WAIT
  } state_t;

  state_t      r_state;
  logic [31:0] r_sreg;
  logic [15:0] r_bit_cnt;
  logic [15:0] r_len;
  logic        r_quad;

  logic [15:0] w_tgt;
  logic        w_last_edge;
  logic        w_word_end;

  // Number of tx_edge steps in the transfer. Quad mode rounds the bit count up
  // to whole nibbles; written as floor(len/4) + (len%4 != 0) so the sum cannot
  // overflow 16 bits for len = 65535.
  assign w_tgt = r_quad ? ({2'b00, r_len[15:2]} + {15'd0, |r_len[1:0]})
                        : r_len;

  // In TRANSMIT the target is never zero (a zero length never leaves IDLE),
  // so tgt-1 cannot underflow while this is used.
  assign w_last_edge = (r_bit_cnt == (w_tgt - 16'd1));

  // Last step of the current 32-bit word: 32 single-bit or 8 nibble steps.
  assign w_word_end = r_quad ? (r_bit_cnt[2:0] == 3'b111)
                             : (r_bit_cnt[4:0] == 5'b11111);

  // Pop request to the FIFO. Held low during reset so no word is lost.
  // NOTE: every output of a combinational block gets a default first so that
  // no path through the case statement leaves it unassigned (no latch).
  always_comb begin
    data_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE:     data_ready = en & data_valid & (r_len != 16'd0);
        S_TRANSMIT: data_ready = tx_edge & ~w_last_edge & w_word_end;
        S_WAIT:     data_ready = 1'b1;
        default:    data_ready = 1'b0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register sees
  // the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sreg    <= 32'd0;
      r_bit_cnt <= 16'd0;
      r_len     <= 16'd0;
      r_quad    <= 1'b0;
      clk_en_o  <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (counter_in_upd) begin
            r_len <= counter_in;
          end
          if (en) begin
            if (r_len == 16'd0) begin
              // Nothing to send: complete immediately without touching the FIFO.
              tx_done <= 1'b1;
            end else if (data_valid) begin
              r_sreg    <= data;
              r_bit_cnt <= 16'd0;
              r_quad    <= en_quad_in;
              clk_en_o  <= 1'b1;
              r_state   <= S_TRANSMIT;
            end
          end
        end

        S_TRANSMIT: begin
          if (tx_edge) begin
            r_bit_cnt <= r_bit_cnt + 16'd1;
            r_sreg    <= r_quad ? {r_sreg[27:0], 4'b0000}
                                : {r_sreg[30:0], 1'b0};
            // Completion wins over reloading: the final step may also be the
            // last step of a word, and no further word must be popped then.
            if (w_last_edge) begin
              clk_en_o <= 1'b0;
              tx_done  <= 1'b1;
              r_state  <= S_IDLE;
            end else if (w_word_end) begin
              if (data_valid) begin
                r_sreg <= data;
              end else begin
                // Stall the SPI clock until the FIFO refills.
                clk_en_o <= 1'b0;
                r_state  <= S_WAIT;
              end
            end
          end
        end

        S_WAIT: begin
          // A trailing tx_edge from the clock generator may arrive here after
          // clk_en_o dropped; it is deliberately not acted on.
          if (data_valid) begin
            r_sreg   <= data;
            clk_en_o <= 1'b1;
            r_state  <= S_TRANSMIT;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lines follow the shift register, which only changes on a load or a
  // tx_edge, so the outputs only move on clock-generator fall edges.
  assign sdo0 = r_quad ? r_sreg[28] : r_sreg[31];
  assign sdo1 = r_quad & r_sreg[29];
  assign sdo2 = r_quad & r_sreg[30];
  assign sdo3 = r_quad & r_sreg[31];

endmodule

// File: tb/tb_spi_master_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_master_tx
//
// Directed bench for spi_master_tx. A small FIFO queue feeds the data port;
// each cycle the bench samples outputs on the falling clock edge, records the
// serial lines at every tx_edge, counts pops, tx_done pulses and clk_en_o
// falls, and each scenario task compares those against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        tx_edge;
  logic        en_quad_in;
  logic [15:0] counter_in;
  logic        counter_in_upd;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        clk_en_o;
  logic        tx_done;
  logic        sdo0, sdo1, sdo2, sdo3;

  always #5 clk = ~clk;

  spi_master_tx dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .tx_edge        (tx_edge),
    .en_quad_in     (en_quad_in),
    .counter_in     (counter_in),
    .counter_in_upd (counter_in_upd),
    .data           (data),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .clk_en_o       (clk_en_o),
    .tx_done        (tx_done),
    .sdo0           (sdo0),
    .sdo1           (sdo1),
    .sdo2           (sdo2),
    .sdo3           (sdo3)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] fifo_q[$];
  logic        fifo_on;
  logic [3:0]  seen_q[$];
  logic [3:0]  exp_q[$];
  logic        rec_on;
  logic        prev_ce;
  int pop_cnt, done_cnt, dr_cnt, ce_fall;
  int cyc_n, last_edge_cyc, done_cyc;

  task automatic fifo_drive();
    data_valid = fifo_on && (fifo_q.size() != 0);
    if (fifo_q.size() != 0) data = fifo_q[0];
    else                    data = 32'h0;
  endtask

  // One clock cycle: observe at the falling edge, then advance past the
  // rising edge and retire any word the DUT popped.
  task automatic cycle();
    logic pop;
    @(negedge clk);
    pop = data_valid & data_ready;
    if (pop) pop_cnt++;
    if (data_ready === 1'b1) dr_cnt++;
    if (tx_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
    if (tx_edge && rec_on) begin
      seen_q.push_back({sdo3, sdo2, sdo1, sdo0});
      last_edge_cyc = cyc_n;
    end
    if (prev_ce === 1'b1 && clk_en_o === 1'b0) ce_fall++;
    prev_ce = clk_en_o;
    @(posedge clk);
    #1;
    cyc_n++;
    if (pop) void'(fifo_q.pop_front());
    fifo_drive();
  endtask

  task automatic do_edge();
    tx_edge = 1'b1;
    cycle();
    tx_edge = 1'b0;
    cycle();
  endtask

  task automatic clear_stats();
    pop_cnt = 0; done_cnt = 0; dr_cnt = 0; ce_fall = 0;
    last_edge_cyc = -100; done_cyc = -200;
    seen_q.delete();
    exp_q.delete();
    rec_on  = 1'b1;
    prev_ce = clk_en_o;
  endtask

  task automatic start_xfer(input logic [15:0] len, input logic quad);
    counter_in     = len;
    counter_in_upd = 1'b1;
    cycle();
    counter_in_upd = 1'b0;
    en_quad_in     = quad;
    en             = 1'b1;
    cycle();
    en             = 1'b0;
    en_quad_in     = 1'b0;
  endtask

  task automatic add_std(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({3'b000, w[31-i]});
  endtask

  task automatic add_quad(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w[31-4*i -: 4]);
  endtask

  // Index of the first disagreement between recorded and expected line
  // sequences, or -1 when they match in length and content.
  function automatic int seq_first_bad();
    int n;
    n = (seen_q.size() < exp_q.size()) ? seen_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (seen_q[i] !== exp_q[i]) return i;
    if (seen_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; tx_edge = 1'b0; en_quad_in = 1'b0;
    counter_in = 16'd0; counter_in_upd = 1'b0; fifo_on = 1'b0;
    cyc_n = 0;
    fifo_drive();
    cycle();
    cycle();
    rst = 1'b0;
    n_vec++;
    if ({clk_en_o, tx_done, data_ready, sdo3, sdo2, sdo1, sdo0} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {clk_en_o, tx_done, data_ready, sdo3, sdo2, sdo1, sdo0});
    end
  endtask

  // Standard mode, 8 bits of 0xA5000000.
  task automatic run_std8(input string tag);
    int bad;
    clear_stats();
    fifo_q.push_back(32'hA500_0000);
    fifo_on = 1'b1;
    fifo_drive();
    start_xfer(16'd8, 1'b0);
    n_vec++;
    if (clk_en_o !== 1'b1) begin
      n_err++; $display("FAIL %s_clk_en_start: got %b want 1", tag, clk_en_o);
    end
    for (int i = 0; i < 8; i++) do_edge();
    add_std(32'hA500_0000, 8);
    bad = seq_first_bad();
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s_sdo_seq: first bad step %0d, got %0d edges want %0d",
               tag, bad, seen_q.size(), exp_q.size());
    end
    n_vec++;
    if (pop_cnt != 1 || done_cnt != 1 || (done_cyc - last_edge_cyc) != 1) begin
      n_err++;
      $display("FAIL %s_counts: pops %0d dones %0d done_lag %0d want 1 1 1",
               tag, pop_cnt, done_cnt, done_cyc - last_edge_cyc);
    end
    n_vec++;
    if (clk_en_o !== 1'b0) begin
      n_err++; $display("FAIL %s_clk_en_end: got %b want 0", tag, clk_en_o);
    end
  endtask

  task automatic test_std_single();
    run_std8("t1");
  endtask

  // Quad, 64 bits from two back-to-back words; a length update mid-transfer
  // must be ignored.
  task automatic test_back_to_back();
    int bad;
    clear_stats();
    fifo_q.push_back(32'h1234_5678);
    fifo_q.push_back(32'h9ABC_DEF0);
    fifo_on = 1'b1;
    fifo_drive();
    start_xfer(16'd64, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i == 4) begin
        counter_in     = 16'd4;
        counter_in_upd = 1'b1;
      end
      do_edge();
      counter_in_upd = 1'b0;
    end
    add_quad(32'h1234_5678, 8);
    add_quad(32'h9ABC_DEF0, 8);
    bad = seq_first_bad();
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL t2_nibble_seq: first bad step %0d, got %0d edges want %0d",
               bad, seen_q.size(), exp_q.size());
    end
    n_vec++;
    if (pop_cnt != 2 || done_cnt != 1 || (done_cyc - last_edge_cyc) != 1) begin
      n_err++;
      $display("FAIL t2_counts: pops %0d dones %0d done_lag %0d want 2 1 1",
               pop_cnt, done_cnt, done_cyc - last_edge_cyc);
    end
    n_vec++;
    if (ce_fall != 1) begin
      n_err++; $display("FAIL t2_no_wait: clk_en falls %0d want 1", ce_fall);
    end
  endtask

  // Standard, 40 bits; the second word arrives late, forcing WAIT.
  task automatic test_underrun_wait();
    int bad;
    clear_stats();
    fifo_q.push_back(32'hDEAD_BEEF);
    fifo_on = 1'b1;
    fifo_drive();
    start_xfer(16'd40, 1'b0);
    for (int i = 0; i < 32; i++) do_edge();
    n_vec++;
    if (clk_en_o !== 1'b0 || data_ready !== 1'b1) begin
      n_err++;
      $display("FAIL t3_wait_state: clk_en %b ready %b want 0 1", clk_en_o, data_ready);
    end
    rec_on  = 1'b0;
    tx_edge = 1'b1;
    cycle();
    tx_edge = 1'b0;
    rec_on  = 1'b1;
    cycle();
    cycle();
    fifo_q.push_back(32'hC300_0000);
    fifo_drive();
    cycle();
    n_vec++;
    if (clk_en_o !== 1'b1) begin
      n_err++; $display("FAIL t3_resume: clk_en %b want 1", clk_en_o);
    end
    for (int i = 0; i < 8; i++) do_edge();
    add_std(32'hDEAD_BEEF, 32);
    add_std(32'hC300_0000, 8);
    bad = seq_first_bad();
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL t3_sdo_seq: first bad step %0d, got %0d edges want %0d",
               bad, seen_q.size(), exp_q.size());
    end
    n_vec++;
    if (pop_cnt != 2 || done_cnt != 1 || (done_cyc - last_edge_cyc) != 1 || ce_fall != 2) begin
      n_err++;
      $display("FAIL t3_counts: pops %0d dones %0d done_lag %0d falls %0d want 2 1 1 2",
               pop_cnt, done_cnt, done_cyc - last_edge_cyc, ce_fall);
    end
  endtask

  // Quad with a length that is not a multiple of 4: 6 bits -> 2 steps.
  task automatic test_quad_roundup();
    int bad;
    clear_stats();
    fifo_q.push_back(32'hAB00_0000);
    fifo_on = 1'b1;
    fifo_drive();
    start_xfer(16'd6, 1'b1);
    do_edge();
    do_edge();
    add_quad(32'hAB00_0000, 2);
    bad = seq_first_bad();
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL t4_nibble_seq: first bad step %0d, got %0d edges want %0d",
               bad, seen_q.size(), exp_q.size());
    end
    n_vec++;
    if (pop_cnt != 1 || done_cnt != 1 || (done_cyc - last_edge_cyc) != 1) begin
      n_err++;
      $display("FAIL t4_counts: pops %0d dones %0d done_lag %0d want 1 1 1",
               pop_cnt, done_cnt, done_cyc - last_edge_cyc);
    end
  endtask

  // Zero length: immediate tx_done, FIFO untouched.
  task automatic test_zero_len();
    clear_stats();
    fifo_q.push_back(32'h1111_1111);
    fifo_on = 1'b1;
    fifo_drive();
    start_xfer(16'd0, 1'b0);
    cycle();
    n_vec++;
    if (done_cnt != 1 || done_cyc != cyc_n - 1) begin
      n_err++;
      $display("FAIL t5_done: dones %0d at cycle %0d want 1 at %0d",
               done_cnt, done_cyc, cyc_n - 1);
    end
    cycle();
    cycle();
    n_vec++;
    if (dr_cnt != 0 || pop_cnt != 0 || fifo_q.size() != 1 || done_cnt != 1) begin
      n_err++;
      $display("FAIL t5_fifo_untouched: ready_cycles %0d pops %0d fifo %0d dones %0d want 0 0 1 1",
               dr_cnt, pop_cnt, fifo_q.size(), done_cnt);
    end
    fifo_q.delete();
    fifo_on = 1'b0;
    fifo_drive();
  endtask

  // Reset in the middle of a 32-bit transfer, then a clean restart.
  task automatic test_reset_abort();
    clear_stats();
    fifo_q.push_back(32'h1234_5678);
    fifo_on = 1'b1;
    fifo_drive();
    start_xfer(16'd32, 1'b0);
    for (int i = 0; i < 10; i++) do_edge();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_vec++;
    if ({clk_en_o, tx_done, data_ready, sdo3, sdo2, sdo1, sdo0} !== 7'b0) begin
      n_err++;
      $display("FAIL t6_abort_outputs: got %b want 0000000",
               {clk_en_o, tx_done, data_ready, sdo3, sdo2, sdo1, sdo0});
    end
    cycle();
    cycle();
    n_vec++;
    if (done_cnt != 0) begin
      n_err++; $display("FAIL t6_no_done: dones %0d want 0", done_cnt);
    end
    run_std8("t6_restart");
  endtask

  initial begin
    test_reset();
    test_std_single();
    test_back_to_back();
    test_underrun_wait();
    test_quad_roundup();
    test_zero_len();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
